// File: rtl/operand_fetch_pipe.sv
// Operand-fetch stage of the NTT/INTT butterfly pipeline.
// Issues coefficient/twiddle read addresses, aligns RD_LAT-delayed memory data
// with request metadata, forwards in-flight write-back data, negates the
// twiddle mod Q in INTT mode and buffers bundles in a credit-checked FIFO.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   i_a/o_rdy_a + i_*_a      fetch request handshake and payload
//   o_ram_addr_*, o_rom_addr read addresses (combinational from request)
//   i_ram_dout_*, i_rom_dout read data, RD_LAT cycles after the address
//   i_wb_*                   write-back bus used for forwarding
//   i_flush                  synchronous clear of delay line and FIFO
//   o_v/i_rdy + o_*_v        output bundle handshake and payload
module operand_fetch_pipe #(
  parameter int unsigned DW         = 12,
  parameter int unsigned AW         = 8,
  parameter int unsigned ZW         = 7,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned Q          = 3329
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_a,
  output logic          o_rdy_a,
  input  logic          i_last_a,
  input  logic          i_done_a,
  input  logic          i_sel_a,
  input  logic [AW-1:0] i_addr_up_a,
  input  logic [AW-1:0] i_addr_dn_a,
  input  logic [ZW-1:0] i_addr_zeta_a,
  output logic [AW-1:0] o_ram_addr_up,
  output logic [AW-1:0] o_ram_addr_dn,
  output logic [ZW-1:0] o_rom_addr,
  input  logic [DW-1:0] i_ram_dout_up,
  input  logic [DW-1:0] i_ram_dout_dn,
  input  logic [DW-1:0] i_rom_dout,
  input  logic          i_wb_v,
  input  logic [AW-1:0] i_wb_addr_up,
  input  logic [AW-1:0] i_wb_addr_dn,
  input  logic [DW-1:0] i_wb_data_up,
  input  logic [DW-1:0] i_wb_data_dn,
  input  logic          i_flush,
  output logic          o_v,
  input  logic          i_rdy,
  output logic          o_last_v,
  output logic          o_done_v,
  output logic          o_sel_v,
  output logic [AW-1:0] o_addr_up_v,
  output logic [AW-1:0] o_addr_dn_v,
  output logic [DW-1:0] o_bu_up_v,
  output logic [DW-1:0] o_bu_dn_v,
  output logic [DW-1:0] o_zeta_v
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OW = CW + 1;

  // In-flight request: metadata plus per-operand forwarding override.
  typedef struct packed {
    logic          v;
    logic          last;
    logic          done;
    logic          sel;
    logic [AW-1:0] addr_up;
    logic [AW-1:0] addr_dn;
    logic          ov_up;
    logic [DW-1:0] ovd_up;
    logic          ov_dn;
    logic [DW-1:0] ovd_dn;
  } slot_t;

  // Captured operand bundle handed to the MUL stage.
  typedef struct packed {
    logic          last;
    logic          done;
    logic          sel;
    logic [AW-1:0] addr_up;
    logic [AW-1:0] addr_dn;
    logic [DW-1:0] bu_up;
    logic [DW-1:0] bu_dn;
    logic [DW-1:0] zeta;
  } bundle_t;

  // Apply this cycle's write-back; up-port match has priority over dn-port.
  function automatic slot_t fwd(input slot_t s, input logic wb_v,
                                input logic [AW-1:0] wa_up, input logic [AW-1:0] wa_dn,
                                input logic [DW-1:0] wd_up, input logic [DW-1:0] wd_dn);
    slot_t r;
    r = s;
    if (wb_v) begin
      if (s.addr_up == wa_up) begin
        r.ov_up  = 1'b1;
        r.ovd_up = wd_up;
      end else if (s.addr_up == wa_dn) begin
        r.ov_up  = 1'b1;
        r.ovd_up = wd_dn;
      end
      if (s.addr_dn == wa_up) begin
        r.ov_dn  = 1'b1;
        r.ovd_dn = wd_up;
      end else if (s.addr_dn == wa_dn) begin
        r.ov_dn  = 1'b1;
        r.ovd_dn = wd_dn;
      end
    end
    return r;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  logic          accept;
  logic [CW-1:0] inflight;
  logic [CW-1:0] fifo_cnt;
  logic [CW-1:0] mem_cnt;
  logic          out_v;
  bundle_t       out_q;
  bundle_t       push_b;
  bundle_t       mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          load;
  logic          from_mem;
  logic          bypass;
  logic          mem_wr;
  logic [DW-1:0] z_neg;
  slot_t         cap;

  // raw[k]: entry issued k cycles ago; cur[k]: same entry after this cycle's forwarding.
  slot_t raw [RD_LAT+1];
  slot_t cur [RD_LAT+1];

  assign o_ram_addr_up = i_addr_up_a;
  assign o_ram_addr_dn = i_addr_dn_a;
  assign o_rom_addr    = i_addr_zeta_a;

  // Credit check counts FIFO contents plus requests still waiting on memory.
  assign fifo_cnt = CW'(out_v) + mem_cnt;
  assign o_rdy_a  = (OW'(fifo_cnt) + OW'(inflight)) < OW'(FIFO_DEPTH);
  assign accept   = i_a & o_rdy_a;

  assign raw[0] = '{v: accept, last: i_last_a, done: i_done_a, sel: i_sel_a,
                    addr_up: i_addr_up_a, addr_dn: i_addr_dn_a,
                    ov_up: 1'b0, ovd_up: DW'(0), ov_dn: 1'b0, ovd_dn: DW'(0)};

  for (genvar k = 0; k <= int'(RD_LAT); k++) begin : g_fwd
    assign cur[k] = fwd(raw[k], i_wb_v, i_wb_addr_up, i_wb_addr_dn, i_wb_data_up, i_wb_data_dn);
  end

  if (RD_LAT > 0) begin : g_pipe
    slot_t pipe_q [RD_LAT];

    // Delay line; flush drops everything including this cycle's issue.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int unsigned i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
      end else begin
        for (int unsigned i = 0; i < RD_LAT; i++) pipe_q[i] <= i_flush ? '0 : cur[i];
      end
    end

    for (genvar k = 1; k <= int'(RD_LAT); k++) begin : g_tap
      assign raw[k] = pipe_q[k-1];
    end

    always_comb begin
      inflight = '0;
      for (int unsigned i = 0; i < RD_LAT; i++) inflight = inflight + CW'(pipe_q[i].v);
    end
  end else begin : g_nopipe
    assign inflight = '0;
  end

  // Capture: memory data arrives now; overrides win over RAM contents.
  assign cap   = cur[RD_LAT];
  assign z_neg = (i_rom_dout == '0) ? '0 : DW'(Q) - i_rom_dout;

  always_comb begin
    push_b         = '0;
    push_b.last    = cap.last;
    push_b.done    = cap.done;
    push_b.sel     = cap.sel;
    push_b.addr_up = cap.addr_up;
    push_b.addr_dn = cap.addr_dn;
    push_b.bu_up   = cap.ov_up ? cap.ovd_up : i_ram_dout_up;
    push_b.bu_dn   = cap.ov_dn ? cap.ovd_dn : i_ram_dout_dn;
    push_b.zeta    = cap.sel ? z_neg : i_rom_dout;
  end

  // Output register is the FIFO head; backing storage refills it (fall-through).
  assign push     = cap.v & ~i_flush;
  assign pop      = out_v & i_rdy;
  assign load     = ~out_v | pop;
  assign from_mem = load & (mem_cnt != '0);
  assign bypass   = load & (mem_cnt == '0) & push;
  assign mem_wr   = push & ~bypass;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_v   <= 1'b0;
      out_q   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      mem_cnt <= '0;
    end else if (i_flush) begin
      out_v   <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      mem_cnt <= '0;
    end else begin
      if (from_mem) begin
        out_q <= mem[rd_ptr];
        out_v <= 1'b1;
      end else if (bypass) begin
        out_q <= push_b;
        out_v <= 1'b1;
      end else if (pop) begin
        out_v <= 1'b0;
      end
      if (mem_wr)   wr_ptr <= ptr_inc(wr_ptr);
      if (from_mem) rd_ptr <= ptr_inc(rd_ptr);
      mem_cnt <= mem_cnt + CW'(mem_wr) - CW'(from_mem);
    end
  end

  // Storage array needs no reset: only entries counted by mem_cnt are read.
  always_ff @(posedge clk) begin
    if (mem_wr) mem[wr_ptr] <= push_b;
  end

  assign o_v         = out_v;
  assign o_last_v    = out_q.last;
  assign o_done_v    = out_q.done;
  assign o_sel_v     = out_q.sel;
  assign o_addr_up_v = out_q.addr_up;
  assign o_addr_dn_v = out_q.addr_dn;
  assign o_bu_up_v   = out_q.bu_up;
  assign o_bu_dn_v   = out_q.bu_dn;
  assign o_zeta_v    = out_q.zeta;

endmodule

// File: doc/operand_fetch_pipe.md
# operand_fetch_pipe

Parametrised operand-fetch stage of the NTT/INTT butterfly pipeline, between the address-decode stage and the MUL stage. It issues up/dn coefficient addresses and a twiddle index to external RAM/ROM of configurable read latency, and aligns returned data with pass-through metadata. It forwards in-flight write-back data to resolve read-after-write hazards and negates the twiddle modulo Q in INTT mode. A credit-checked output FIFO provides valid/ready backpressure, which the previous fixed two-cycle fetch stage did not have.

## Interface
- DW, 12, coefficient/twiddle width
- AW, 8, coefficient RAM address width
- ZW, 7, twiddle ROM address width
- RD_LAT, 1, RAM and ROM read latency in cycles (0, 1 or 2; both memories identical)
- FIFO_DEPTH, 4, output FIFO entries; must be >= RD_LAT+2
- Q, 3329, modulus for twiddle negation
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- i_a  in  1  fetch request valid
- o_rdy_a  out  1  request accepted this cycle when high with i_a
- i_last_a, i_done_a, i_sel_a  in  1 each  last-stage flag, done pulse, mode (0 NTT, 1 INTT)
- i_addr_up_a, i_addr_dn_a  in  AW  coefficient addresses
- i_addr_zeta_a  in  ZW  twiddle index
- o_ram_addr_up, o_ram_addr_dn  out  AW  RAM read addresses
- o_rom_addr  out  ZW  ROM read address
- i_ram_dout_up, i_ram_dout_dn  in  DW  RAM data, RD_LAT cycles after address
- i_rom_dout  in  DW  ROM data, RD_LAT cycles after address
- i_wb_v  in  1  write-back valid
- i_wb_addr_up, i_wb_addr_dn  in  AW  write-back addresses
- i_wb_data_up, i_wb_data_dn  in  DW  write-back data
- i_flush  in  1  synchronous pipeline/FIFO clear
- o_v  out  1  output bundle valid
- i_rdy  in  1  MUL stage ready
- o_last_v, o_done_v, o_sel_v  out  1 each  aligned metadata
- o_addr_up_v, o_addr_dn_v  out  AW  aligned addresses
- o_bu_up_v, o_bu_dn_v  out  DW  operands
- o_zeta_v  out  DW  twiddle (negated when sel=1)

## Operation
- Accept = i_a & o_rdy_a. o_rdy_a = (fifo_count + inflight) < FIFO_DEPTH; combinational from registers.
- Address outputs are combinational copies of request inputs, driven every cycle regardless of accept.
- Accepted request enters a delay line of RD_LAT+1 stages carrying metadata, addresses, and per-operand override flag/data.
- Forwarding: for every cycle the entry is in flight (issue cycle through capture cycle), if i_wb_v and its address equals i_wb_addr_up, set the override to i_wb_data_up; else, if it equals i_wb_addr_dn, set it to i_wb_data_dn. The latest cycle wins; up match beats dn match within a cycle. This applies independently to the up and dn operands.
- Capture cycle (issue + RD_LAT): operand = override if set, else RAM data. Twiddle z = i_rom_dout. If sel=1, z' = (z==0) ? 0 : Q−z; else z' = z. Width is DW; z < Q is guaranteed by the ROM.
- Captured bundle is written to the FIFO (first-word fall-through into output registers). Pop on o_v & i_rdy.
- Output fields hold stable while o_v & !i_rdy.
- i_flush: clears delay line valids, FIFO, and count; o_v=0 next cycle. Requests issued in the flush cycle are dropped.

## Timing
- Reset: o_v, all o_* data/metadata = 0; FIFO empty; inflight = 0; o_rdy_a = 1 (combinational on cleared state).
- Latency: accept at edge t -> o_v high in cycle t+RD_LAT+1 when the FIFO is empty (RD_LAT=1 gives 2 cycles).
- Throughput: 1 bundle/cycle while i_rdy=1.
- Full: o_rdy_a=0 when fifo_count+inflight = FIFO_DEPTH. No data loss under any i_rdy pattern.
- Simultaneous pop and push on a full FIFO: allowed. o_rdy_a does not see the same-cycle pop (conservative).
- Async reset mid-operation discards all in-flight entries immediately.

## Test plan
- RD_LAT=1, i_rdy=1, request up=3, dn=131, zeta=1, sel=0, RAM returns 100/200, ROM returns 17 -> o_v two cycles later with up=100, dn=200, zeta=17, addresses 3/131.
- Same request with sel=1, ROM=17 -> o_zeta_v=3312. With ROM=0 -> 0.
- Issue up=5. In the issue cycle i_wb_v with addr_up=5, data=999. Next cycle i_wb_addr_dn=5, data=777 -> o_bu_up_v=777 (latest wins). RAM value is ignored.
- FIFO_DEPTH=4, RD_LAT=1, i_rdy=0, continuous i_a -> exactly 4 accepted, then o_rdy_a=0. Raise i_rdy -> 4 bundles drain in order, one per cycle.
- Random i_rdy toggling over 256 requests, RD_LAT ∈ {0,1,2} -> output sequence equals scoreboard, outputs stable while stalled.
- Assert i_flush with 3 entries queued -> o_v=0 next cycle, o_rdy_a=1. Assert rst mid-stream -> all outputs 0 asynchronously.
